// File: rtl/sal_sched_frfcfs_if.sv
// Request/grant/command bundle between the per-bank controllers, the
// inter-bank scheduler and the command encoder.
interface sal_sched_frfcfs_if #(
    parameter int BK_CNT = 4,
    parameter int RA_W   = 14,
    parameter int CA_W   = 10,
    parameter int ID_W   = 4,
    parameter int LEN_W  = 4
) ();
    localparam int BA_W = $clog2(BK_CNT);

    logic [BK_CNT-1:0]       req_rd;
    logic [BK_CNT-1:0]       req_wr;
    logic [BK_CNT-1:0]       req_pre;
    logic [BK_CNT-1:0]       req_act;
    logic [BK_CNT-1:0]       req_ref;
    logic [BK_CNT*RA_W-1:0]  req_ra;
    logic [BK_CNT*CA_W-1:0]  req_ca;
    logic [BK_CNT*ID_W-1:0]  req_id;
    logic [BK_CNT*LEN_W-1:0] req_len;

    logic [BK_CNT-1:0]       gnt_rd;
    logic [BK_CNT-1:0]       gnt_wr;
    logic [BK_CNT-1:0]       gnt_pre;
    logic [BK_CNT-1:0]       gnt_act;
    logic [BK_CNT-1:0]       gnt_ref;

    logic                    cmd_rd;
    logic                    cmd_wr;
    logic                    cmd_pre;
    logic                    cmd_act;
    logic                    cmd_ref;
    logic [BA_W-1:0]         cmd_ba;
    logic [RA_W-1:0]         cmd_ra;
    logic [CA_W-1:0]         cmd_ca;
    logic [ID_W-1:0]         cmd_id;
    logic [LEN_W-1:0]        cmd_len;

    // bank-controller side: raises requests, receives grants and commands
    modport master (
        output req_rd, req_wr, req_pre, req_act, req_ref,
        output req_ra, req_ca, req_id, req_len,
        input  gnt_rd, gnt_wr, gnt_pre, gnt_act, gnt_ref,
        input  cmd_rd, cmd_wr, cmd_pre, cmd_act, cmd_ref,
        input  cmd_ba, cmd_ra, cmd_ca, cmd_id, cmd_len
    );

    // scheduler side
    modport slave (
        input  req_rd, req_wr, req_pre, req_act, req_ref,
        input  req_ra, req_ca, req_id, req_len,
        output gnt_rd, gnt_wr, gnt_pre, gnt_act, gnt_ref,
        output cmd_rd, cmd_wr, cmd_pre, cmd_act, cmd_ref,
        output cmd_ba, cmd_ra, cmd_ca, cmd_id, cmd_len
    );
endinterface

// File: rtl/sal_sched_frfcfs.sv
// Inter-bank command scheduler: at most one command per cycle, chosen
// combinationally from current requests and registered timing state.
// Priority: starved bank first, then round-robin or column-first scan
// starting at the round-robin pointer. Enforces tRRD, tCCD, tWTR, tRTW
// and the four-activate (tFAW) window.
module sal_sched_frfcfs #(
    parameter int BK_CNT = 4,
    parameter int RA_W   = 14,
    parameter int CA_W   = 10,
    parameter int ID_W   = 4,
    parameter int LEN_W  = 4,
    parameter int T_W    = 6,
    parameter int AGE_W  = 4
) (
    input  logic           i_clk,
    input  logic           i_rst,
    input  logic           i_mode,
    input  logic [T_W-1:0] i_t_rrd_m1,
    input  logic [T_W-1:0] i_t_ccd_m1,
    input  logic [T_W-1:0] i_t_wtr_m1,
    input  logic [T_W-1:0] i_t_rtw_m1,
    input  logic [T_W-1:0] i_t_faw_m1,
    sal_sched_frfcfs_if.slave bus
);
    localparam int               BA_W    = $clog2(BK_CNT);
    localparam logic [AGE_W-1:0] AGE_MAX = '1;

    typedef enum logic [2:0] {
        C_NONE,
        C_RD,
        C_WR,
        C_PRE,
        C_ACT,
        C_REF
    } cand_t;

    logic [T_W-1:0]   r_rrd;
    logic [T_W-1:0]   r_ccd;
    logic [T_W-1:0]   r_wtr;
    logic [T_W-1:0]   r_rtw;
    logic [T_W-1:0]   r_faw [4];
    logic [AGE_W-1:0] r_age [BK_CNT];
    logic [BA_W-1:0]  r_rr_ptr;

    logic             w_rd_ok;
    logic             w_wr_ok;
    logic             w_act_ok;
    logic [2:0]       w_faw_busy;
    logic [1:0]       w_faw_slot;
    cand_t            w_cand [BK_CNT];
    logic             w_gnt_vld;
    logic [BA_W-1:0]  w_sel;
    cand_t            w_sel_cand;

    logic [BK_CNT-1:0] w_gnt_rd;
    logic [BK_CNT-1:0] w_gnt_wr;
    logic [BK_CNT-1:0] w_gnt_pre;
    logic [BK_CNT-1:0] w_gnt_act;
    logic [BK_CNT-1:0] w_gnt_ref;
    logic [BA_W-1:0]   w_cmd_ba;
    logic [RA_W-1:0]   w_cmd_ra;
    logic [CA_W-1:0]   w_cmd_ca;
    logic [ID_W-1:0]   w_cmd_id;
    logic [LEN_W-1:0]  w_cmd_len;

    function automatic logic [T_W-1:0] f_dec(input logic [T_W-1:0] v);
        return (v == '0) ? '0 : v - T_W'(1);
    endfunction

    // Command legality from timing counters; also finds the lowest free tFAW slot
    always_comb begin
        w_faw_busy = '0;
        w_faw_slot = '0;
        for (int s = 3; s >= 0; s--) begin
            if (r_faw[s] != '0) begin
                w_faw_busy = w_faw_busy + 3'd1;
            end else begin
                w_faw_slot = 2'(s);
            end
        end
        w_rd_ok  = (r_ccd == '0) && (r_wtr == '0);
        w_wr_ok  = (r_ccd == '0) && (r_rtw == '0);
        w_act_ok = (r_rrd == '0) && (w_faw_busy < 3'd4);
    end

    // Per-bank candidate: highest-priority legal request RD > WR > PRE > ACT > REF
    always_comb begin
        for (int b = 0; b < BK_CNT; b++) begin
            w_cand[b] = C_NONE;
            if (bus.req_rd[b] && w_rd_ok) begin
                w_cand[b] = C_RD;
            end else if (bus.req_wr[b] && w_wr_ok) begin
                w_cand[b] = C_WR;
            end else if (bus.req_pre[b]) begin
                w_cand[b] = C_PRE;
            end else if (bus.req_act[b] && w_act_ok) begin
                w_cand[b] = C_ACT;
            end else if (bus.req_ref[b]) begin
                w_cand[b] = C_REF;
            end
        end
    end

    // Bank selection: starvation overrides; then mode-dependent scan from rr_ptr
    always_comb begin
        logic            f_st;
        logic            f_any;
        logic            f_col;
        logic            f_row;
        logic [BA_W-1:0] b_st;
        logic [BA_W-1:0] b_any;
        logic [BA_W-1:0] b_col;
        logic [BA_W-1:0] b_row;
        logic [BA_W-1:0] idx;
        f_st  = 1'b0;
        f_any = 1'b0;
        f_col = 1'b0;
        f_row = 1'b0;
        b_st  = '0;
        b_any = '0;
        b_col = '0;
        b_row = '0;
        idx   = '0;
        for (int i = 0; i < BK_CNT; i++) begin
            idx = r_rr_ptr + BA_W'(i);
            if (!f_st && (r_age[idx] == AGE_MAX) && (w_cand[idx] != C_NONE)) begin
                f_st = 1'b1;
                b_st = idx;
            end
            if (!f_any && (w_cand[idx] != C_NONE)) begin
                f_any = 1'b1;
                b_any = idx;
            end
            if (!f_col && ((w_cand[idx] == C_RD) || (w_cand[idx] == C_WR))) begin
                f_col = 1'b1;
                b_col = idx;
            end
            if (!f_row && ((w_cand[idx] == C_PRE) || (w_cand[idx] == C_ACT) ||
                           (w_cand[idx] == C_REF))) begin
                f_row = 1'b1;
                b_row = idx;
            end
        end

        w_gnt_vld = 1'b0;
        w_sel     = '0;
        if (f_st) begin
            w_gnt_vld = 1'b1;
            w_sel     = b_st;
        end else if (!i_mode) begin
            w_gnt_vld = f_any;
            w_sel     = b_any;
        end else if (f_col) begin
            w_gnt_vld = 1'b1;
            w_sel     = b_col;
        end else begin
            w_gnt_vld = f_row;
            w_sel     = b_row;
        end

        // reset blanks every grant and command
        if (i_rst) begin
            w_gnt_vld = 1'b0;
            w_sel     = '0;
        end
        w_sel_cand = w_gnt_vld ? w_cand[w_sel] : C_NONE;
    end

    // Grant vectors and command fields; unused fields are held at zero
    always_comb begin
        w_gnt_rd  = '0;
        w_gnt_wr  = '0;
        w_gnt_pre = '0;
        w_gnt_act = '0;
        w_gnt_ref = '0;
        w_cmd_ba  = '0;
        w_cmd_ra  = '0;
        w_cmd_ca  = '0;
        w_cmd_id  = '0;
        w_cmd_len = '0;
        if (w_gnt_vld) begin
            case (w_sel_cand)
                C_RD:    w_gnt_rd[w_sel]  = 1'b1;
                C_WR:    w_gnt_wr[w_sel]  = 1'b1;
                C_PRE:   w_gnt_pre[w_sel] = 1'b1;
                C_ACT:   w_gnt_act[w_sel] = 1'b1;
                C_REF:   w_gnt_ref[w_sel] = 1'b1;
                default: ;
            endcase
            w_cmd_ba = w_sel;
            w_cmd_ra = bus.req_ra[int'(w_sel)*RA_W +: RA_W];
            w_cmd_ca = bus.req_ca[int'(w_sel)*CA_W +: CA_W];
            if ((w_sel_cand == C_RD) || (w_sel_cand == C_WR)) begin
                w_cmd_id  = bus.req_id[int'(w_sel)*ID_W +: ID_W];
                w_cmd_len = bus.req_len[int'(w_sel)*LEN_W +: LEN_W];
            end
        end
    end

    assign bus.gnt_rd  = w_gnt_rd;
    assign bus.gnt_wr  = w_gnt_wr;
    assign bus.gnt_pre = w_gnt_pre;
    assign bus.gnt_act = w_gnt_act;
    assign bus.gnt_ref = w_gnt_ref;
    assign bus.cmd_rd  = |w_gnt_rd;
    assign bus.cmd_wr  = |w_gnt_wr;
    assign bus.cmd_pre = |w_gnt_pre;
    assign bus.cmd_act = |w_gnt_act;
    assign bus.cmd_ref = |w_gnt_ref;
    assign bus.cmd_ba  = w_cmd_ba;
    assign bus.cmd_ra  = w_cmd_ra;
    assign bus.cmd_ca  = w_cmd_ca;
    assign bus.cmd_id  = w_cmd_id;
    assign bus.cmd_len = w_cmd_len;

    // Inter-command timers: load on the issuing grant, otherwise count down to 0
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rrd <= '0;
            r_ccd <= '0;
            r_wtr <= '0;
            r_rtw <= '0;
        end else begin
            r_rrd <= (w_sel_cand == C_ACT) ? i_t_rrd_m1 : f_dec(r_rrd);
            r_ccd <= ((w_sel_cand == C_RD) || (w_sel_cand == C_WR)) ? i_t_ccd_m1 : f_dec(r_ccd);
            r_wtr <= (w_sel_cand == C_WR) ? i_t_wtr_m1 : f_dec(r_wtr);
            r_rtw <= (w_sel_cand == C_RD) ? i_t_rtw_m1 : f_dec(r_rtw);
        end
    end

    // tFAW window: an ACT claims the lowest idle slot, all other slots count down
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int s = 0; s < 4; s++) begin
                r_faw[s] <= '0;
            end
        end else begin
            for (int s = 0; s < 4; s++) begin
                if ((w_sel_cand == C_ACT) && (2'(s) == w_faw_slot)) begin
                    r_faw[s] <= i_t_faw_m1;
                end else begin
                    r_faw[s] <= f_dec(r_faw[s]);
                end
            end
        end
    end

    // Starvation age: grows while a bank waits, clears on grant or when idle
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int b = 0; b < BK_CNT; b++) begin
                r_age[b] <= '0;
            end
        end else begin
            for (int b = 0; b < BK_CNT; b++) begin
                if (!(bus.req_rd[b] | bus.req_wr[b] | bus.req_pre[b] |
                      bus.req_act[b] | bus.req_ref[b]) ||
                    (w_gnt_vld && (w_sel == BA_W'(b)))) begin
                    r_age[b] <= '0;
                end else if (r_age[b] != AGE_MAX) begin
                    r_age[b] <= r_age[b] + AGE_W'(1);
                end
            end
        end
    end

    // Round-robin pointer moves just past the granted bank
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rr_ptr <= '0;
        end else if (w_gnt_vld) begin
            r_rr_ptr <= w_sel + BA_W'(1);
        end
    end
endmodule

// File: tb/tb_sal_sched_frfcfs.sv
// Scheduler bench: directed scenarios plus randomized traffic, all checked
// against a behavioural model of the scheduling rules.
module tb_sal_sched_frfcfs;
    localparam int BK    = 4;
    localparam int RA_W  = 14;
    localparam int CA_W  = 10;
    localparam int ID_W  = 4;
    localparam int LEN_W = 4;
    localparam int T_W   = 6;
    localparam int AGE_W = 2;
    localparam int AMAX  = (1 << AGE_W) - 1;

    logic           clk = 1'b0;
    logic           rst;
    logic           mode;
    logic [T_W-1:0] t_rrd, t_ccd, t_wtr, t_rtw, t_faw;

    always #5 clk = ~clk;

    sal_sched_frfcfs_if #(.BK_CNT(BK), .RA_W(RA_W), .CA_W(CA_W), .ID_W(ID_W),
                          .LEN_W(LEN_W)) bus ();

    sal_sched_frfcfs #(.BK_CNT(BK), .RA_W(RA_W), .CA_W(CA_W), .ID_W(ID_W),
                       .LEN_W(LEN_W), .T_W(T_W), .AGE_W(AGE_W)) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_mode     (mode),
        .i_t_rrd_m1 (t_rrd),
        .i_t_ccd_m1 (t_ccd),
        .i_t_wtr_m1 (t_wtr),
        .i_t_rtw_m1 (t_rtw),
        .i_t_faw_m1 (t_faw),
        .bus        (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // reference state; request kinds: 0 RD, 1 WR, 2 PRE, 3 ACT, 4 REF
    int m_rrd, m_ccd, m_wtr, m_rtw, m_ptr;
    int m_faw [4];
    int m_age [BK];
    logic [4:0]       m_req [BK];
    logic [RA_W-1:0]  m_ra  [BK];
    logic [CA_W-1:0]  m_ca  [BK];
    logic [ID_W-1:0]  m_id  [BK];
    logic [LEN_W-1:0] m_len [BK];
    int refill [BK];   // mask re-issued after a grant; -1 = random traffic

    logic [19:0] o_gnt;
    logic [4:0]  o_cmd;
    int          o_ba;

    function automatic bit legal(int k);
        int busy = 0;
        foreach (m_faw[s]) if (m_faw[s] != 0) busy++;
        case (k)
            0:       return (m_ccd == 0) && (m_wtr == 0);
            1:       return (m_ccd == 0) && (m_rtw == 0);
            3:       return (m_rrd == 0) && (busy < 4);
            default: return 1'b1;
        endcase
    endfunction

    function automatic int cand(int b);
        for (int k = 0; k < 5; k++) if (m_req[b][k] && legal(k)) return k;
        return -1;
    endfunction

    function automatic int pick();
        int order[$];
        for (int i = 0; i < BK; i++) order.push_back((m_ptr + i) % BK);
        foreach (order[j]) if (m_age[order[j]] == AMAX && cand(order[j]) >= 0) return order[j];
        if (!mode) begin
            foreach (order[j]) if (cand(order[j]) >= 0) return order[j];
        end else begin
            foreach (order[j]) if (cand(order[j]) == 0 || cand(order[j]) == 1) return order[j];
            foreach (order[j]) if (cand(order[j]) >= 2) return order[j];
        end
        return -1;
    endfunction

    function automatic int dec(int v);
        return (v > 0) ? v - 1 : 0;
    endfunction

    function automatic logic [4:0] new_mask();
        int r = $urandom_range(0, 9);
        if (r < 3) return 5'd0;
        if (r < 8) return 5'(1 << $urandom_range(0, 4));
        return 5'($urandom_range(1, 31));
    endfunction

    task automatic new_req(input int b, input logic [4:0] mask);
        m_req[b] = mask;
        m_ra[b]  = RA_W'($urandom);
        m_ca[b]  = CA_W'($urandom);
        m_id[b]  = ID_W'($urandom);
        m_len[b] = LEN_W'($urandom);
    endtask

    task automatic model_reset();
        m_rrd = 0; m_ccd = 0; m_wtr = 0; m_rtw = 0; m_ptr = 0;
        foreach (m_faw[s]) m_faw[s] = 0;
        foreach (m_age[b]) m_age[b] = 0;
    endtask

    task automatic drive();
        for (int b = 0; b < BK; b++) begin
            bus.req_rd[b]  = m_req[b][0];
            bus.req_wr[b]  = m_req[b][1];
            bus.req_pre[b] = m_req[b][2];
            bus.req_act[b] = m_req[b][3];
            bus.req_ref[b] = m_req[b][4];
            bus.req_ra[b*RA_W +: RA_W]    = m_ra[b];
            bus.req_ca[b*CA_W +: CA_W]    = m_ca[b];
            bus.req_id[b*ID_W +: ID_W]    = m_id[b];
            bus.req_len[b*LEN_W +: LEN_W] = m_len[b];
        end
    endtask

    // one cycle: drive, check combinational outputs, clock, advance the model
    task automatic step();
        int sel, kind, free_slot;
        logic [19:0] e_gnt;
        logic [4:0]  e_cmd;
        drive();
        #1;
        sel   = rst ? -1 : pick();
        kind  = (sel >= 0) ? cand(sel) : -1;
        e_gnt = '0;
        e_cmd = '0;
        if (kind >= 0) begin
            e_gnt[kind*BK + sel] = 1'b1;
            e_cmd[kind] = 1'b1;
        end
        o_gnt = {bus.gnt_ref, bus.gnt_act, bus.gnt_pre, bus.gnt_wr, bus.gnt_rd};
        o_cmd = {bus.cmd_ref, bus.cmd_act, bus.cmd_pre, bus.cmd_wr, bus.cmd_rd};
        o_ba  = int'(bus.cmd_ba);
        chk("gnt", 64'(o_gnt), 64'(e_gnt));
        chk("cmd", 64'(o_cmd), 64'(e_cmd));
        chk("ba",  64'(bus.cmd_ba), (sel >= 0) ? 64'(sel) : 64'd0);
        chk("ra",  64'(bus.cmd_ra), (sel >= 0) ? 64'(m_ra[sel]) : 64'd0);
        chk("ca",  64'(bus.cmd_ca), (sel >= 0) ? 64'(m_ca[sel]) : 64'd0);
        chk("id",  64'(bus.cmd_id), (kind == 0 || kind == 1) ? 64'(m_id[sel]) : 64'd0);
        chk("len", 64'(bus.cmd_len), (kind == 0 || kind == 1) ? 64'(m_len[sel]) : 64'd0);
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            free_slot = -1;
            for (int s = 0; s < 4; s++) if (m_faw[s] == 0 && free_slot < 0) free_slot = s;
            for (int s = 0; s < 4; s++)
                m_faw[s] = (kind == 3 && s == free_slot) ? int'(t_faw) : dec(m_faw[s]);
            m_rrd = (kind == 3) ? int'(t_rrd) : dec(m_rrd);
            m_ccd = (kind == 0 || kind == 1) ? int'(t_ccd) : dec(m_ccd);
            m_wtr = (kind == 1) ? int'(t_wtr) : dec(m_wtr);
            m_rtw = (kind == 0) ? int'(t_rtw) : dec(m_rtw);
            for (int b = 0; b < BK; b++) begin
                if (m_req[b] == 0 || b == sel) m_age[b] = 0;
                else if (m_age[b] < AMAX) m_age[b]++;
            end
            if (sel >= 0) begin
                m_ptr = (sel + 1) % BK;
                new_req(sel, (refill[sel] < 0) ? new_mask() : 5'(refill[sel]));
            end
            for (int b = 0; b < BK; b++)
                if (refill[b] < 0 && m_req[b] == 0 && b != sel) new_req(b, new_mask());
        end
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic set_t(input int rrd, input int ccd, input int wtr, input int rtw, input int faw);
        t_rrd = T_W'(rrd); t_ccd = T_W'(ccd); t_wtr = T_W'(wtr);
        t_rtw = T_W'(rtw); t_faw = T_W'(faw);
    endtask

    task automatic set_reqs(input logic [4:0] m0, input logic [4:0] m1,
                            input logic [4:0] m2, input logic [4:0] m3,
                            input int rf0, input int rf1, input int rf2, input int rf3);
        new_req(0, m0); new_req(1, m1); new_req(2, m2); new_req(3, m3);
        refill[0] = rf0; refill[1] = rf1; refill[2] = rf2; refill[3] = rf3;
    endtask

    initial begin
        int first_rd, first_pre, first_act, n_act, fifth;
        logic [4:0] pat;
        rst  = 1'b1;
        mode = 1'b0;
        set_t(0, 0, 0, 0, 0);
        model_reset();
        set_reqs(0, 0, 0, 0, 0, 0, 0, 0);
        drive();
        @(posedge clk);
        #1;
        do_reset();

        // single RD on bank 2, then pointer sits at bank 3
        set_reqs(0, 0, 5'b00001, 0, 0, 0, 0, 0);
        step();
        chk("t1_gnt_rd", 64'(o_gnt[3:0]), 64'b0100);
        chk("t1_ba", 64'(o_ba), 64'd2);
        set_reqs(5'b00001, 0, 0, 5'b00001, 0, 0, 0, 0);
        step();
        chk("t1_ptr_ba", 64'(o_ba), 64'd3);

        // tCCD spacing of back-to-back reads
        do_reset();
        set_t(0, 3, 0, 0, 0);
        set_reqs(5'b00001, 5'b00001, 0, 0, 1, 1, 0, 0);
        pat = '0;
        for (int c = 0; c < 5; c++) begin
            step();
            pat[c] = o_cmd[0];
        end
        chk("ccd_pattern", 64'(pat), 64'b10001);

        // write-to-read turnaround; precharge slips in meanwhile
        do_reset();
        set_t(0, 0, 5, 0, 0);
        set_reqs(5'b00010, 5'b00001, 5'b00100, 0, 0, 0, 0, 0);
        first_rd = -1; first_pre = -1;
        for (int c = 0; c < 9; c++) begin
            step();
            if (o_cmd[0] && first_rd < 0) first_rd = c;
            if (o_cmd[2] && first_pre < 0) first_pre = c;
        end
        chk("wtr_rd_cycle", 64'(first_rd), 64'd6);
        chk("wtr_pre_cycle", 64'(first_pre), 64'd1);

        // four-activate window
        do_reset();
        set_t(0, 0, 0, 0, 19);
        set_reqs(5'b01000, 5'b01000, 5'b01000, 5'b01000, 8, 8, 8, 8);
        n_act = 0; fifth = -1;
        for (int c = 0; c < 22; c++) begin
            step();
            if (o_cmd[3]) begin
                n_act++;
                if (n_act == 5) fifth = c;
            end
        end
        chk("faw_fifth_cycle", 64'(fifth), 64'd20);

        // column-first vs round-robin
        do_reset();
        mode = 1'b1;
        set_reqs(5'b01000, 0, 0, 5'b00001, 0, 0, 0, 0);
        step();
        chk("cf_first_ba", 64'(o_ba), 64'd3);
        chk("cf_first_rd", 64'(o_cmd), 64'b00001);
        step();
        chk("cf_second_act", 64'(o_cmd), 64'b01000);
        do_reset();
        mode = 1'b0;
        set_reqs(5'b01000, 0, 0, 5'b00001, 0, 0, 0, 0);
        step();
        chk("rr_first_act", 64'(o_cmd), 64'b01000);
        chk("rr_first_ba", 64'(o_ba), 64'd0);

        // starvation overrides column-first
        do_reset();
        mode = 1'b1;
        set_t(0, 0, 0, 0, 0);
        set_reqs(5'b00001, 5'b01000, 5'b00001, 5'b00001, 1, 8, 1, 1);
        first_act = -1;
        for (int c = 0; c < 6; c++) begin
            step();
            if (o_cmd[3] && first_act < 0) first_act = c;
        end
        chk("age_act_cycle", 64'(first_act), 64'd3);

        // randomized traffic, timing and mode, with a reset mid-run
        for (int b = 0; b < BK; b++) refill[b] = -1;
        for (int seg = 0; seg < 8; seg++) begin
            set_t($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 6),
                  $urandom_range(0, 6), $urandom_range(0, 24));
            mode = 1'($urandom_range(0, 1));
            for (int c = 0; c < 200; c++) begin
                if (c == 100) mode = ~mode;
                if (seg == 4 && c == 57) begin
                    rst = 1'b1;
                    step();
                    rst = 1'b0;
                end else begin
                    step();
                end
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/sal_sched_frfcfs.md
Name: sal_sched_frfcfs

Overview:
- Next-generation inter-bank command scheduler for the DDR2 controller. Sits between the per-bank controllers and the command encoder; issues at most one command per cycle.
- Generalises the round-robin scheduler in four ways: parametrised bank count and field widths, a selectable column-first (row-hit-first) mode, tFAW four-activate window enforcement, and per-bank starvation aging that overrides normal priority.

Parameters:
- BK_CNT, 4, number of banks (≥2, power of two).
- RA_W, 14, row address width.
- CA_W, 10, column address width.
- ID_W, 4, request ID width.
- LEN_W, 4, burst length field width.
- T_W, 6, width of every timing input and timing counter.
- AGE_W, 4, age counter width; AGE_MAX = 2^AGE_W-1.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- mode  in  1  0 = round-robin, 1 = column-first.
- t_rrd_m1, t_ccd_m1, t_wtr_m1, t_rtw_m1, t_faw_m1  in  T_W each  timing values minus 1.
- req_rd, req_wr, req_pre, req_act, req_ref  in  BK_CNT each  per-bank request bits.
- req_ra  in  BK_CNT*RA_W  per-bank row address.
- req_ca  in  BK_CNT*CA_W  per-bank column address.
- req_id  in  BK_CNT*ID_W  per-bank request ID.
- req_len  in  BK_CNT*LEN_W  per-bank burst length.
- gnt_rd, gnt_wr, gnt_pre, gnt_act, gnt_ref  out  BK_CNT each  per-bank grants, at most one bit set across all five.
- cmd_rd, cmd_wr, cmd_pre, cmd_act, cmd_ref  out  1 each  command strobes to the encoder, one-hot or all zero.
- cmd_ba  out  log2(BK_CNT)  selected bank.
- cmd_ra  out  RA_W  selected row address.
- cmd_ca  out  CA_W  selected column address.
- cmd_id  out  ID_W  ID; zero unless RD or WR.
- cmd_len  out  LEN_W  burst length; zero unless RD or WR.

Behaviour:
- Grants and cmd_* are combinational from the current-cycle requests and registered state (0-cycle latency). A bank must hold its request until granted.
- State is updated on the clock edge that follows a grant.
- Reset: all counters, ages and rr_ptr = 0.
- While rst = 1, all gnt_* and cmd_* are forced to 0.
- Any field of an output that is not set by the rules above is driven to 0.
- Counters rrd, ccd, wtr, rtw decrement each cycle and saturate at 0. They load on grant:
  - ACT loads rrd with t_rrd_m1.
  - RD or WR loads ccd with t_ccd_m1.
  - WR loads wtr with t_wtr_m1.
  - RD loads rtw with t_rtw_m1.
  - A load takes priority over the decrement in the same cycle.
- Legality rules:
  - RD is legal when ccd = 0 and wtr = 0.
  - WR is legal when ccd = 0 and rtw = 0.
  - PRE and REF are always legal.
  - ACT is legal when rrd = 0 and fewer than 4 tFAW slots are nonzero.
- tFAW: four T_W down-counters (slots). On an ACT grant, the lowest-index slot that is 0 loads t_faw_m1. Other slots decrement in the same cycle.
- Per-bank candidate: the bank's highest-priority legal request, in the order RD > WR > PRE > ACT > REF. If it has no legal request, the bank has no candidate.
- Aging, per bank:
  - age increments (saturating at AGE_MAX) when the bank has any request bit set and is not granted.
  - age clears when the bank is granted or has no request.
- Selection, first rule that yields a bank wins. Every scan starts at rr_ptr and wraps modulo BK_CNT.
  1. Starvation: the first bank with age = AGE_MAX and a candidate. This applies in either mode.
  2. mode = 0: the first bank with any candidate.
  3. mode = 1: the first bank whose candidate is RD or WR. If there is none, the first bank whose candidate is PRE, ACT or REF.
- On any grant, rr_ptr <= (sel_bank + 1) mod BK_CNT. With no grant, rr_ptr holds.
- A mode change takes effect in the same cycle. No state is flushed.
- Reset asserted mid-operation clears all counters and ages on the next edge. A tFAW window in progress is discarded; the bench accounts for this.

Test Plan:
- Reset, then rd on bank 2 only → gnt_rd = 4'b0100, cmd_rd = 1, cmd_ba = 2, cmd_id = req_id[2] in the same cycle. rr_ptr = 3 next cycle.
- t_ccd_m1 = 3, rd held on banks 0 and 1 → grants on cycles 0 and 4 only. Cycles 1–3 produce no grant.
- t_wtr_m1 = 5: WR at cycle 0, then rd pending → RD is not granted before cycle 6. A pending pre on another bank is granted at cycle 1.
- t_rrd_m1 = 0, t_faw_m1 = 19, act on all 4 banks plus a fifth request → four ACTs at cycles 0–3. The fifth ACT is granted no earlier than cycle 20.
- mode = 1, rr_ptr = 0, bank 0 act, bank 3 rd (legal) → bank 3 RD granted first, bank 0 ACT next cycle. With mode = 0, bank 0 ACT is granted first.
- AGE_W = 2, mode = 1, bank 1 act continuously and other banks issuing back-to-back legal RDs → bank 1 is granted on the cycle after its age reaches 3, even though an RD is ready.
